// File: rtl/regs_writeback.sv
// regs_writeback -- write-side sequencer for the 16-entry register file.
//
// Writeback requests (ALU result, memory load, SP update) are accepted on a
// valid/ready handshake, queued in a DEPTH-entry FIFO and issued as at most
// one register write per cycle. A wide (32-bit) request becomes two writes:
// lo -> dst, then hi -> dst+1 (4-bit wrap). Target register 0 is a discard
// target: its slot and cycle are still spent, but no write strobe is issued.
//
// Optional feature: define REGS_WB_BYPASS_EN to let a request accepted while
// the FIFO is empty and the sequencer is idle load the output registers
// directly at the acceptance edge (one cycle less latency).
//
// Ports:
//   cpu_clk, rst          clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_dst/wide/lo/hi    request payload
//   we, src_w, val        registered register-file write port
//   rd_a, rd_b            register addresses being read
//   hazard_a, hazard_b    a not-yet-committed write targets rd_a / rd_b
//   count                 FIFO occupancy
//   busy                  FIFO non-empty, high half pending, or write in flight
module regs_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                   cpu_clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_dst,
    input  logic                   req_wide,
    input  logic [15:0]            req_lo,
    input  logic [15:0]            req_hi,
    output logic                   we,
    output logic [3:0]             src_w,
    output logic [15:0]            val,
    input  logic [3:0]             rd_a,
    input  logic [3:0]             rd_b,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic {ISSUE, HIGH} state_t;

    state_t          state_q, state_d;
    logic [3:0]      f_dst  [DEPTH];
    logic            f_wide [DEPTH];
    logic [15:0]     f_lo   [DEPTH];
    logic [15:0]     f_hi   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic [3:0]      hold_dst, hold_dst_d;   // already dst+1 of the held entry
    logic [15:0]     hold_hi, hold_hi_d;
    logic            we_d;
    logic [3:0]      src_d;
    logic [15:0]     val_d;

    logic            push, pop, fifo_push, take;
    logic [3:0]      c_dst;
    logic            c_wide;
    logic [15:0]     c_lo, c_hi;

    assign req_ready = ~rst & (cnt != FULL);
    assign push      = req_valid & req_ready;
    assign count     = cnt;
    assign busy      = (cnt != '0) | (state_q == HIGH) | we;

    // Candidate entry for an ISSUE cycle: normally the FIFO head; with the
    // bypass enabled and the FIFO empty, the incoming request itself.
    always_comb begin
        c_dst     = f_dst[rd_ptr];
        c_wide    = f_wide[rd_ptr];
        c_lo      = f_lo[rd_ptr];
        c_hi      = f_hi[rd_ptr];
        take      = (cnt != '0);
        fifo_push = push;
`ifdef REGS_WB_BYPASS_EN
        if (state_q == ISSUE && cnt == '0) begin
            c_dst     = req_dst;
            c_wide    = req_wide;
            c_lo      = req_lo;
            c_hi      = req_hi;
            take      = push;
            fifo_push = 1'b0;
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        src_d      = 4'd0;
        val_d      = 16'd0;
        pop        = 1'b0;
        hold_dst_d = hold_dst;
        hold_hi_d  = hold_hi;
        case (state_q)
            ISSUE: begin
                if (take) begin
                    pop = (cnt != '0);
                    if (c_dst != 4'd0) begin
                        we_d  = 1'b1;
                        src_d = c_dst;
                        val_d = c_lo;
                    end
                    if (c_wide) begin
                        state_d    = HIGH;
                        hold_dst_d = c_dst + 4'd1;
                        hold_hi_d  = c_hi;
                    end
                end
            end
            HIGH: begin
                // dst=15 wraps the high half onto register 0: dropped.
                if (hold_dst != 4'd0) begin
                    we_d  = 1'b1;
                    src_d = hold_dst;
                    val_d = hold_hi;
                end
                state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q  <= ISSUE;
            we       <= 1'b0;
            src_w    <= 4'd0;
            val      <= 16'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            hold_dst <= 4'd0;
            hold_hi  <= 16'd0;
        end else begin
            state_q  <= state_d;
            we       <= we_d;
            src_w    <= src_d;
            val      <= val_d;
            hold_dst <= hold_dst_d;
            hold_hi  <= hold_hi_d;
            if (fifo_push) begin
                f_dst[wr_ptr]  <= req_dst;
                f_wide[wr_ptr] <= req_wide;
                f_lo[wr_ptr]   <= req_lo;
                f_hi[wr_ptr]   <= req_hi;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(fifo_push) - (AW+1)'(pop);
        end
    end

    // One bit per register: set if any uncommitted write targets it.
    logic [15:0]   pend;
    logic [AW-1:0] off;
    logic [3:0]    nx;
    always_comb begin
        pend = 16'd0;
        off  = '0;
        nx   = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            nx  = f_dst[i] + 4'd1;
            if ({1'b0, off} < cnt) begin
                pend[f_dst[i]] = 1'b1;
                if (f_wide[i])
                    pend[nx] = 1'b1;
            end
        end
        if (state_q == HIGH)
            pend[hold_dst] = 1'b1;
        if (we)
            pend[src_w] = 1'b1;
        pend[0] = 1'b0;
    end

    assign hazard_a = pend[rd_a];
    assign hazard_b = pend[rd_b];

endmodule

// File: tb/tb_regs_writeback.sv
// Directed self-checking bench for regs_writeback (default build, DEPTH=4).
module tb_regs_writeback;

    logic        cpu_clk, rst;
    logic        req_valid, req_ready, req_wide;
    logic [3:0]  req_dst, src_w, rd_a, rd_b;
    logic [15:0] req_lo, req_hi, val;
    logic        we, hazard_a, hazard_b, busy;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [19:0] wq[$];

    regs_writeback #(.DEPTH(4)) dut (
        .cpu_clk(cpu_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_wide(req_wide), .req_lo(req_lo), .req_hi(req_hi),
        .we(we), .src_w(src_w), .val(val),
        .rd_a(rd_a), .rd_b(rd_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .count(count), .busy(busy)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Record every issued register write.
    always @(negedge cpu_clk)
        if (we === 1'b1) wq.push_back({src_w, val});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic w, input logic [15:0] lo,
                        input logic [15:0] hi, output int waits);
        logic r;
        req_valid = 1'b1; req_dst = d; req_wide = w; req_lo = lo; req_hi = hi;
        waits = 0;
        while (1) begin
            r = req_ready;
            tick();
            if (r) break;
            waits++;
            if (waits > 50) begin
                chk("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        rst = 1'b1; req_valid = 1'b0; req_dst = 4'd0; req_wide = 1'b0;
        req_lo = 16'd0; req_hi = 16'd0; rd_a = 4'd0; rd_b = 4'd0;

        // 1: reset, then reset again mid-traffic
        tick(); tick();
        chk("rst_ready_lo", 32'(req_ready), 32'd0);
        rst = 1'b0; #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_src", 32'(src_w), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready_hi", 32'(req_ready), 32'd1);
        send(4'd2, 1'b1, 16'h1111, 16'h2222, w);
        send(4'd4, 1'b1, 16'h3333, 16'h4444, w);
        rst = 1'b1; #1;
        chk("midrst_ready_lo", 32'(req_ready), 32'd0);
        tick(); tick();
        rst = 1'b0; #1;
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_src", 32'(src_w), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        wq.delete();
        repeat (4) tick();
        chk("midrst_no_writes", 32'(wq.size()), 32'd0);

        // 2: single write, latency 2, hazard until commit
        rd_a = 4'd3;
        send(4'd3, 1'b0, 16'h1234, 16'h0000, w);
        chk("single_count", 32'(count), 32'd1);
        chk("single_we0", 32'(we), 32'd0);
        chk("single_haz_q", 32'(hazard_a), 32'd1);
        tick();
        chk("single_we", 32'(we), 32'd1);
        chk("single_src", 32'(src_w), 32'd3);
        chk("single_val", 32'(val), 32'h1234);
        chk("single_haz_out", 32'(hazard_a), 32'd1);
        tick();
        chk("single_we_off", 32'(we), 32'd0);
        chk("single_src_off", 32'(src_w), 32'd0);
        chk("single_haz_off", 32'(hazard_a), 32'd0);
        chk("single_busy_off", 32'(busy), 32'd0);

        // 3: wide write splits into lo then hi
        rd_a = 4'd15;
        send(4'd14, 1'b1, 16'hBEEF, 16'h0001, w);
        chk("wide_count", 32'(count), 32'd1);
        chk("wide_haz_hi_q", 32'(hazard_a), 32'd1);
        tick();
        chk("wide_lo", 32'({we, src_w, val}), 32'({1'b1, 4'd14, 16'hBEEF}));
        chk("wide_haz_held", 32'(hazard_a), 32'd1);
        chk("wide_busy", 32'(busy), 32'd1);
        tick();
        chk("wide_hi", 32'({we, src_w, val}), 32'({1'b1, 4'd15, 16'h0001}));
        chk("wide_haz_out", 32'(hazard_a), 32'd1);
        tick();
        chk("wide_we_off", 32'(we), 32'd0);
        chk("wide_haz_off", 32'(hazard_a), 32'd0);

        // 4: fill the FIFO behind wide entries; stall and ordering
        wq.delete();
        for (int k = 1; k <= 8; k++) begin
            send(4'(k), 1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), w);
            if (k == 7) begin
                chk("full_count", 32'(count), 32'd4);
                chk("full_ready", 32'(req_ready), 32'd0);
            end
            if (k == 8) begin
                chk("full_stall_cycles", 32'(w), 32'd1);
                chk("full_count_again", 32'(count), 32'd4);
            end
        end
        drain();
        chk("full_nwrites", 32'(wq.size()), 32'd16);
        for (int k = 1; k <= 8; k++) begin
            if (wq.size() >= 2 * k) begin
                chk($sformatf("full_lo%0d", k), 32'(wq[2*k-2]), 32'({4'(k), 16'h1000 + 16'(k)}));
                chk($sformatf("full_hi%0d", k), 32'(wq[2*k-1]), 32'({4'(k+1), 16'h2000 + 16'(k)}));
            end
        end

        // 5: zero target and wide dst=15 (high half wraps to 0)
        wq.delete();
        rd_a = 4'd0; rd_b = 4'd15;
        send(4'd0, 1'b0, 16'hFFFF, 16'h0000, w);
        chk("zero_count", 32'(count), 32'd1);
        chk("zero_haz_a", 32'(hazard_a), 32'd0);
        send(4'd15, 1'b1, 16'hAAAA, 16'h5555, w);
        chk("zero_we_off", 32'(we), 32'd0);
        chk("zero_src_off", 32'(src_w), 32'd0);
        chk("zero_count2", 32'(count), 32'd1);
        chk("zero_haz_b", 32'(hazard_b), 32'd1);
        tick();
        chk("zero_w15", 32'({we, src_w, val}), 32'({1'b1, 4'd15, 16'hAAAA}));
        chk("zero_busy_high", 32'(busy), 32'd1);
        chk("zero_haz_a_high", 32'(hazard_a), 32'd0);
        tick();
        chk("zero_hi_drop", 32'({we, src_w}), 32'd0);
        chk("zero_haz_b_off", 32'(hazard_b), 32'd0);
        chk("zero_busy_off", 32'(busy), 32'd0);
        tick();
        chk("zero_nwrites", 32'(wq.size()), 32'd1);

        // 6: two writes to the same register
        wq.delete();
        rd_a = 4'd0; rd_b = 4'd5;
        send(4'd5, 1'b0, 16'h0001, 16'h0000, w);
        chk("same_haz_q", 32'(hazard_b), 32'd1);
        send(4'd5, 1'b0, 16'h0002, 16'h0000, w);
        chk("same_first", 32'({we, src_w, val}), 32'({1'b1, 4'd5, 16'h0001}));
        chk("same_haz_1", 32'(hazard_b), 32'd1);
        tick();
        chk("same_second", 32'({we, src_w, val}), 32'({1'b1, 4'd5, 16'h0002}));
        chk("same_haz_2", 32'(hazard_b), 32'd1);
        tick();
        chk("same_haz_off", 32'(hazard_b), 32'd0);
        chk("same_we_off", 32'(we), 32'd0);
        chk("same_nwrites", 32'(wq.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
